// File: rtl/dct_pkg.sv
// Shared defaults, FSM state encoding and level-shift constant for the DCT coefficient accumulator.
// Build option DCT_LEVEL_SHIFT_EN (see dct_mac) selects JPEG-style pixel level shifting.
package dct_pkg;

  localparam int DCT_FRAC_BITS   = 8;
  localparam int DCT_ACC_W       = 32;
  localparam int DCT_COEF_W      = 16;
  localparam int DCT_LEVEL_SHIFT = 128;
  localparam int DCT_LAST_IDX    = 63;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT
  } dct_acc_state_t;

endpackage

// File: rtl/dct_mac.sv
// Cosine alignment register, pixel x cosine multiply, accumulator and round/saturate of the result.
// DCT_LEVEL_SHIFT_EN defined: pixel becomes pixel-128 before the multiply; undefined: zero-extended pixel.
module dct_mac
  import dct_pkg::*;
#(
  parameter int FRAC_BITS = DCT_FRAC_BITS,
  parameter int ACC_W     = DCT_ACC_W,
  parameter int COEF_W    = DCT_COEF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cap_en,
  input  logic [31:0]       cos_term,
  input  logic [7:0]        pixel_data,
  output logic              pend,
  output logic [COEF_W-1:0] result
);

  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(2 ** (FRAC_BITS - 1));
  localparam logic signed [ACC_W:0] CMAX = (ACC_W+1)'(2 ** (COEF_W - 1) - 1);
  localparam logic signed [ACC_W:0] CMIN = -CMAX - 1;

  logic signed [31:0]      cos_reg;
  logic                    acc_en;
  logic signed [ACC_W-1:0] acc;
  logic signed [8:0]       pix_s;
  logic signed [40:0]      pix_x;
  logic signed [40:0]      cos_x;
  logic signed [40:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W:0]   rsum;
  logic signed [ACC_W:0]   rsh;

`ifdef DCT_LEVEL_SHIFT_EN
  assign pix_s = $signed({1'b0, pixel_data} - 9'(DCT_LEVEL_SHIFT));
`else
  assign pix_s = $signed({1'b0, pixel_data});
`endif

  assign pix_x    = 41'(pix_s);
  assign cos_x    = 41'(cos_reg);
  assign prod     = pix_x * cos_x;
  assign prod_ext = ACC_W'(prod);

  // acc_en marks that cos_reg holds a term whose pixel is on pixel_data now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_reg <= '0;
      acc_en  <= 1'b0;
      acc     <= '0;
    end else begin
      acc_en <= cap_en;
      if (cap_en) cos_reg <= cos_term;
      if (clr)         acc <= '0;
      else if (acc_en) acc <= acc + prod_ext;
    end
  end

  assign pend = acc_en;

  // Round half up, floor-shift, then clamp into the signed output range
  assign rsum = {acc[ACC_W-1], acc} + RND;
  assign rsh  = rsum >>> FRAC_BITS;

  always_comb begin
    result = rsh[COEF_W-1:0];
    if (rsh > CMAX)      result = CMAX[COEF_W-1:0];
    else if (rsh < CMIN) result = CMIN[COEF_W-1:0];
  end

endmodule

// File: rtl/dct_coef_accum.sv
// Sequences 64 LUT/pixel reads for one (k1,k2) and emits one rounded, saturated DCT coefficient.
// 66 cycles start to out_valid; coef held while out_ready is low. Option DCT_LEVEL_SHIFT_EN lives in dct_mac.
module dct_coef_accum
  import dct_pkg::*;
#(
  parameter int FRAC_BITS = DCT_FRAC_BITS,
  parameter int ACC_W     = DCT_ACC_W,
  parameter int COEF_W    = DCT_COEF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [2:0]        n1,
  output logic [2:0]        n2,
  input  logic [31:0]       cos_term,
  input  logic [7:0]        pixel_data,
  output logic              busy,
  output logic [COEF_W-1:0] coef,
  output logic              out_valid,
  input  logic              out_ready
);

  dct_acc_state_t    state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              armed_q;
  logic              accept;
  logic              load_coef;
  logic              mac_pend;
  logic [COEF_W-1:0] mac_result;
  logic [COEF_W-1:0] coef_q;

  // armed_q blocks a start sampled on the first edge after reset release
  assign accept    = (state_q == IDLE) && start && armed_q;
  assign load_coef = (state_q == DRAIN) && !mac_pend;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        if (cnt_q == 6'(DCT_LAST_IDX)) state_d = DRAIN;
        else                            cnt_d   = cnt_q + 6'd1;
      end
      DRAIN: if (!mac_pend) state_d = OUT;
      OUT:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      coef_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
      if (load_coef) coef_q <= mac_result;
    end
  end

  assign n1        = cnt_q[5:3];
  assign n2        = cnt_q[2:0];
  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign out_valid = (state_q == OUT);
  assign coef      = coef_q;

  dct_mac #(
    .FRAC_BITS(FRAC_BITS),
    .ACC_W    (ACC_W),
    .COEF_W   (COEF_W)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept),
    .cap_en    (state_q == ISSUE),
    .cos_term  (cos_term),
    .pixel_data(pixel_data),
    .pend      (mac_pend),
    .result    (mac_result)
  );

endmodule
